mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multicycle control state machine for the 32-bit MIPS core. It takes the decoded opcode and funct fields from the instruction register and drives every datapath control signal: memory write, IR/PC enables, mux selects, ALUOp and register-file write. It sits directly upstream of the core datapath, which consumes all of its outputs. It executes one instruction per 3–5 clock cycles.

## Interface
- N, 32: datapath width; used only for documentation consistency, no width-dependent logic.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- OP_code  in  6  instruction opcode field from the IR.
- Funct  in  6  R-type funct field from the IR.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  register write address: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU x operand: 0 = PC, 1 = A.
- ALUSrcB  out  3  ALU y operand: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2, 4 = shamt.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = by funct, 11 = or.
- PCSource  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump address.
- PCWriteCond  out  1  PC write enable, qualified by ALU zero (beq).
- PCWrite  out  1  unconditional PC write enable.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Moore FSM with one-hot or binary encoding (implementer's choice). Outputs are a pure function of state. The single exception is the R-type execute ALUSrcB, which also depends on Funct (see Configuration).
- All outputs default to 0 in every state unless listed below.
- States and their outputs:
  - FETCH: IRWrite=1, ALUSrcB=1, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcB=3 (precompute branch target). Next by opcode:
    - 0x00 → REXE
    - 0x23 / 0x2B → MEMADR
    - 0x04 → BEQ
    - 0x08 → ADDIEXE
    - 0x0D → ORIEXE
    - 0x02 → JUMP
    - any other → ILLEGAL
  - MEMADR: ALUSrcA=1, ALUSrcB=2. Next: MEMRD if lw (0x23), MEMWR if sw (0x2B).
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - REXE: ALUSrcA=1, ALUSrcB=0, ALUOp=10. Next: ALUWB_RD.
  - ALUWB_RD: RegWrite=1, RegDst=1. Next: FETCH.
  - ADDIEXE: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next: ALUWB_RT.
  - ORIEXE: ALUSrcA=1, ALUSrcB=2, ALUOp=11. Next: ALUWB_RT.
  - ALUWB_RT: RegWrite=1, RegDst=0. Next: FETCH.
  - BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=1. Next: FETCH.
  - JUMP: PCWrite=1, PCSource=2. Next: FETCH.
  - ILLEGAL: illegal_op=1, no other writes. Next: FETCH (the instruction is skipped; PC was already advanced in FETCH).
- The FSM does not interpret OP_code in any state other than DECODE and MEMADR. OP_code is stable from the IR after FETCH.

## Timing
- rst low: state forced to FETCH asynchronously. All outputs are gated to 0 while rst = 0, including the FETCH outputs.
- First rising edge after rst deasserts completes the first fetch.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j: 3
  - illegal: 3
- rst asserted mid-instruction: instruction abandoned, no further writes, restart at FETCH.
- MemWrite and RegWrite are never asserted in the same cycle. PCWrite and PCWriteCond are never both 1.

## Configuration
- MIPS_CTRL_SHAMT_EN defined:
  - In REXE, Funct ∈ {0x00 sll, 0x02 srl, 0x03 sra} drives ALUSrcB=4 (shamt). ALUSrcA and ALUOp are unchanged.
  - Other funct values use ALUSrcB=0.
- MIPS_CTRL_SHAMT_EN undefined: REXE always drives ALUSrcB=0, and Funct is ignored by the FSM. ALUSrcB value 4 is never produced.

## Structure
- Shared package/defines file (alongside the existing memory-space defines) holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J)
  - funct constants for the shifts
  - ALUOp encodings
  - ALUSrcB encodings
  - PCSource encodings
  - the state encoding
- No sub-module: one state register block plus combinational next-state and output decode.

## Test plan
- Reset: hold rst=0 for 3 cycles with OP_code=0x23 → all outputs 0. Release → first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=1.
- lw (0x23): sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. Check MEMRD IorD=1 and MEMWB RegWrite=1, MemtoReg=1. Then back to FETCH.
- sw (0x2B) then R-type add (op 0x00, funct 0x20):
  - sw asserts MemWrite=1, IorD=1 in cycle 4, with RegWrite=0 throughout.
  - add gives REXE ALUOp=10, then RegWrite=1, RegDst=1 in cycle 4.
- beq (0x04), j (0x02), ori (0x0D):
  - beq: cycle 3 shows PCWriteCond=1, PCSource=1, ALUOp=01.
  - j: cycle 3 shows PCWrite=1, PCSource=2.
  - ori: cycle 3 shows ALUOp=11, ALUSrcB=2.
- Illegal op 0x3F → illegal_op=1 for exactly one cycle in cycle 3, no write strobes, then FETCH. Also assert rst=0 during MEMRD of a lw → all outputs 0 immediately and no MEMWB.
- With MIPS_CTRL_SHAMT_EN: sll (op 0, funct 0x00) → REXE ALUSrcB=4. Without the macro → ALUSrcB=0.

Source files
------------

// File: rtl/mips_control_fsm_pkg.sv
// rtl/mips_control_fsm_pkg.sv - opcode, funct, mux-select and state encodings for the MIPS control FSM
package mips_control_fsm_pkg;

  localparam int N = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;
  localparam logic [2:0] SRCB_SHAMT   = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_REXE,
    ST_ALUWB_RD,
    ST_ADDIEXE,
    ST_ORIEXE,
    ST_ALUWB_RT,
    ST_BEQ,
    ST_JUMP,
    ST_ILLEGAL
  } state_t;

  function automatic logic is_shift_funct(input logic [5:0] funct);
    return (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);
  endfunction

endpackage

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multicycle MIPS control FSM (Moore outputs, gated by reset)
// Optional MIPS_CTRL_SHAMT_EN: shift functs select shamt as ALU y operand in REXE.
module mips_control_fsm
  import mips_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP_code,
  input  logic [5:0] Funct,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       illegal_op
);

  state_t state;
  state_t state_next;
  logic [2:0] rexe_srcb;

`ifdef MIPS_CTRL_SHAMT_EN
  assign rexe_srcb = is_shift_funct(Funct) ? SRCB_SHAMT : SRCB_B;
`else
  logic unused_funct;
  assign unused_funct = ^Funct;
  assign rexe_srcb    = SRCB_B;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FETCH;
    else      state <= state_next;
  end

  // OP_code is only looked at in DECODE and MEMADR; it is held in the IR after FETCH.
  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        case (OP_code)
          OP_RTYPE:      state_next = ST_REXE;
          OP_LW, OP_SW:  state_next = ST_MEMADR;
          OP_BEQ:        state_next = ST_BEQ;
          OP_ADDI:       state_next = ST_ADDIEXE;
          OP_ORI:        state_next = ST_ORIEXE;
          OP_J:          state_next = ST_JUMP;
          default:       state_next = ST_ILLEGAL;
        endcase
      end
      ST_MEMADR:   state_next = (OP_code == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:    state_next = ST_MEMWB;
      ST_REXE:     state_next = ST_ALUWB_RD;
      ST_ADDIEXE:  state_next = ST_ALUWB_RT;
      ST_ORIEXE:   state_next = ST_ALUWB_RT;
      default:     state_next = ST_FETCH;
    endcase
  end

  // Reset gates every output, so FETCH strobes do not appear while rst is held low.
  always_comb begin
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    illegal_op  = 1'b0;
    if (rst) begin
      case (state)
        ST_FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        ST_DECODE: ALUSrcB = SRCB_IMM_SH2;
        ST_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_MEMRD: IorD = 1'b1;
        ST_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        ST_REXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = rexe_srcb;
          ALUOp   = ALUOP_FUNCT;
        end
        ST_ALUWB_RD: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_ADDIEXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        ST_ORIEXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_OR;
        end
        ST_ALUWB_RT: RegWrite = 1'b1;
        ST_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        ST_ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// tb/tb_mips_control_fsm.sv - randomized instruction-stream bench for mips_control_fsm
module tb_mips_control_fsm;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write_cond;
    logic       pc_write;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OP_code = 6'h23;
  logic [5:0] Funct = 6'h00;
  logic       MemWrite, IRWrite, IorD, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [1:0] ALUOp, PCSource;
  logic       PCWriteCond, PCWrite, illegal_op;

  int n_checks = 0;
  int n_fail   = 0;
  ctl_t obs;
  ctl_t exp_q[$];

  mips_control_fsm dut (
    .clk(clk), .rst(rst), .OP_code(OP_code), .Funct(Funct),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWriteCond(PCWriteCond),
    .PCWrite(PCWrite), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = '{MemWrite, IRWrite, IorD, MemtoReg, RegDst, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource, PCWriteCond, PCWrite, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: the per-cycle control word list of one instruction, from the instruction table.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] funct);
    ctl_t c;
    c = '0; c.ir_write = 1; c.alu_src_b = 1; c.pc_write = 1; exp_q.push_back(c);
    c = '0; c.alu_src_b = 3;                                 exp_q.push_back(c);
    c = '0;
    case (op)
      6'h23: begin
        c.alu_src_a = 1; c.alu_src_b = 2; exp_q.push_back(c);
        c = '0; c.iord = 1; exp_q.push_back(c);
        c = '0; c.reg_write = 1; c.mem_to_reg = 1; exp_q.push_back(c);
      end
      6'h2B: begin
        c.alu_src_a = 1; c.alu_src_b = 2; exp_q.push_back(c);
        c = '0; c.iord = 1; c.mem_write = 1; exp_q.push_back(c);
      end
      6'h00: begin
        c.alu_src_a = 1; c.alu_op = 2;
`ifdef MIPS_CTRL_SHAMT_EN
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) c.alu_src_b = 4;
`endif
        exp_q.push_back(c);
        c = '0; c.reg_write = 1; c.reg_dst = 1; exp_q.push_back(c);
      end
      6'h08, 6'h0D: begin
        c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = (op == 6'h0D) ? 2'd3 : 2'd0;
        exp_q.push_back(c);
        c = '0; c.reg_write = 1; exp_q.push_back(c);
      end
      6'h04: begin
        c.alu_src_a = 1; c.alu_op = 1; c.pc_write_cond = 1; c.pc_source = 1;
        exp_q.push_back(c);
      end
      6'h02: begin
        c.pc_write = 1; c.pc_source = 2; exp_q.push_back(c);
      end
      default: begin
        c.illegal = 1; exp_q.push_back(c);
      end
    endcase
  endtask

  // Entered and left at negedge+1 with the DUT in FETCH; abort_at >= 0 pulls rst low in that cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                           input int abort_at);
    int cyc;
    OP_code = op;
    Funct   = funct;
    exp_q.delete();
    model_instr(op, funct);
    cyc = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s cyc%0d op=%h fn=%h", name, cyc + 1, op, funct), 32'(obs), 32'(exp_q.pop_front()));
      check($sformatf("%s cyc%0d mem/reg write excl", name, cyc + 1), 32'(MemWrite & RegWrite), 32'd0);
      check($sformatf("%s cyc%0d pcw/pcwc excl", name, cyc + 1), 32'(PCWrite & PCWriteCond), 32'd0);
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check($sformatf("%s abort immediate", name), 32'(obs), 32'd0);
        @(negedge clk); #1;
        check($sformatf("%s abort held", name), 32'(obs), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        return;
      end
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    ctl_t fetch_c;
    logic [5:0] legal_ops[7];
    logic [5:0] op, fn;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02};
    fetch_c = '0; fetch_c.ir_write = 1; fetch_c.alu_src_b = 1; fetch_c.pc_write = 1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset hold %0d", i), 32'(obs), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("reset release fetch", 32'(obs), 32'(fetch_c));

    run_instr("lw",   6'h23, 6'h00, -1);
    run_instr("sw",   6'h2B, 6'h11, -1);
    run_instr("add",  6'h00, 6'h20, -1);
    run_instr("beq",  6'h04, 6'h00, -1);
    run_instr("j",    6'h02, 6'h00, -1);
    run_instr("ori",  6'h0D, 6'h00, -1);
    run_instr("addi", 6'h08, 6'h03, -1);
    run_instr("ill",  6'h3F, 6'h00, -1);
    run_instr("lw_abort", 6'h23, 6'h00, 3);
    check("after abort fetch", 32'(obs), 32'(fetch_c));
    run_instr("sll", 6'h00, 6'h00, -1);
    run_instr("srl", 6'h00, 6'h02, -1);
    run_instr("sra", 6'h00, 6'h03, -1);
    run_instr("or",  6'h00, 6'h25, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 6)];
      else                           op = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      run_instr("rand", op, fn, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
